// File: rtl/opb_register_bank_ppc2simulink.sv
// rtl/opb_register_bank_ppc2simulink.sv - OPB slave register bank feeding user_data_out
// Optional double buffering with a commit control word: define OPB_REG_BANK_COMMIT_EN.
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR   = 32'h0100_0300,
  parameter logic [31:0] C_HIGHADDR   = 32'h0100_03FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter string       C_FAMILY     = "virtex5",
  parameter int          C_NUM_REGS   = 4,
  parameter logic [31:0] C_INIT       = 32'h0
) (
  input  logic                        OPB_Clk,
  input  logic                        OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1]   OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
  input  logic                        OPB_RNW,
  input  logic                        OPB_select,
  input  logic                        OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
  output logic                        Sl_xferAck,
  output logic                        Sl_errAck,
  output logic                        Sl_retry,
  output logic                        Sl_toutSup,
  output logic [32*C_NUM_REGS-1:0]    user_data_out,
  output logic                        user_update
);

  localparam bit unused_family = (C_FAMILY == "virtex5");

  logic [31:0] addr;
  logic [31:0] offset;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [29:0] idx;
  logic        hit;
  logic        ack_q;
  logic [31:0] dbus_q;
  logic        update_q;
  logic        wr_cycle;
  logic        reg_wr;
  logic [31:0] rd_mux;
  logic [31:0] regs_q [C_NUM_REGS];
  logic        unused_bits;

  // OPB bit 0 is the MSB, so plain assignment puts OPB_DBus[0] on bit 31 and OPB_BE[0] on byte 3.
  assign addr   = OPB_ABus;
  assign wdata  = OPB_DBus;
  assign be     = OPB_BE;
  assign offset = addr - C_BASEADDR;
  assign idx    = offset[31:2];
  assign hit    = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);

  assign wr_cycle = ack_q && hit && !OPB_RNW;
  assign reg_wr   = wr_cycle && (idx < 30'(C_NUM_REGS));

  assign unused_bits = ^{OPB_seqAddr, offset[1:0], unused_family};

  assign Sl_errAck   = 1'b0;
  assign Sl_retry    = 1'b0;
  assign Sl_toutSup  = 1'b0;
  assign Sl_xferAck  = ack_q;
  assign Sl_DBus     = dbus_q;
  assign user_update = update_q;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  ben);
    logic [31:0] res;
    for (int j = 0; j < 4; j++) begin
      res[8*j +: 8] = ben[j] ? new_v[8*j +: 8] : old_v[8*j +: 8];
    end
    return res;
  endfunction

`ifdef OPB_REG_BANK_COMMIT_EN
  logic        pending_q;
  logic        ctrl_wr;
  logic [31:0] out_q [C_NUM_REGS];

  // Commit needs the strobe bit with its byte lane enabled.
  assign ctrl_wr = wr_cycle && (idx == 30'(C_NUM_REGS)) && be[0] && wdata[0];
`endif

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < C_NUM_REGS; k++) begin
      if (idx == 30'(k)) rd_mux = regs_q[k];
    end
`ifdef OPB_REG_BANK_COMMIT_EN
    if (idx == 30'(C_NUM_REGS)) rd_mux = {31'b0, pending_q};
`endif
  end

  // Ack is suppressed in the cycle after an ack, so a held select re-acks every second cycle.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      ack_q  <= 1'b0;
      dbus_q <= '0;
    end else begin
      ack_q  <= hit && !ack_q;
      dbus_q <= (hit && !ack_q && OPB_RNW) ? rd_mux : '0;
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      for (int k = 0; k < C_NUM_REGS; k++) regs_q[k] <= C_INIT;
    end else begin
      for (int k = 0; k < C_NUM_REGS; k++) begin
        if (wr_cycle && (idx == 30'(k))) regs_q[k] <= merge_bytes(regs_q[k], wdata, be);
      end
    end
  end

`ifdef OPB_REG_BANK_COMMIT_EN
  // regs_q act as shadows; out_q only moves on a commit.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      pending_q <= 1'b0;
      update_q  <= 1'b0;
      for (int k = 0; k < C_NUM_REGS; k++) out_q[k] <= C_INIT;
    end else begin
      update_q <= ctrl_wr;
      if (ctrl_wr) begin
        pending_q <= 1'b0;
        for (int k = 0; k < C_NUM_REGS; k++) out_q[k] <= regs_q[k];
      end else if (reg_wr) begin
        pending_q <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < C_NUM_REGS; k++) begin : g_out
    assign user_data_out[32*k +: 32] = out_q[k];
  end
`else
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) update_q <= 1'b0;
    else         update_q <= reg_wr;
  end

  for (genvar k = 0; k < C_NUM_REGS; k++) begin : g_out
    assign user_data_out[32*k +: 32] = regs_q[k];
  end
`endif

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// tb/tb_opb_register_bank_ppc2simulink.sv - directed self-checking bench for the OPB register bank
module tb_opb_register_bank_ppc2simulink;

  localparam logic [31:0] BASE = 32'h0100_0300;
  localparam logic [31:0] HIGH = 32'h0100_03FF;
  localparam logic [31:0] INIT = 32'hA5A5_0000;
  localparam int          NREG = 4;
`ifdef OPB_REG_BANK_COMMIT_EN
  localparam bit COMMIT = 1'b1;
`else
  localparam bit COMMIT = 1'b0;
`endif

  logic               OPB_Clk = 1'b0;
  logic               OPB_Rst;
  logic [0:31]        OPB_ABus;
  logic [0:3]         OPB_BE;
  logic [0:31]        OPB_DBus;
  logic               OPB_RNW;
  logic               OPB_select;
  logic               OPB_seqAddr;
  logic [0:31]        Sl_DBus;
  logic               Sl_xferAck;
  logic               Sl_errAck;
  logic               Sl_retry;
  logic               Sl_toutSup;
  logic [32*NREG-1:0] user_data_out;
  logic               user_update;

  int n_checks = 0;
  int n_errors = 0;

  opb_register_bank_ppc2simulink #(
    .C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .C_NUM_REGS(NREG), .C_INIT(INIT)
  ) dut (
    .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst), .OPB_ABus(OPB_ABus), .OPB_BE(OPB_BE),
    .OPB_DBus(OPB_DBus), .OPB_RNW(OPB_RNW), .OPB_select(OPB_select),
    .OPB_seqAddr(OPB_seqAddr), .Sl_DBus(Sl_DBus), .Sl_xferAck(Sl_xferAck),
    .Sl_errAck(Sl_errAck), .Sl_retry(Sl_retry), .Sl_toutSup(Sl_toutSup),
    .user_data_out(user_data_out), .user_update(user_update)
  );

  always #5 OPB_Clk = ~OPB_Clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts and ends on a falling edge; lat = cycles from select to ack, 0 if never acked.
  task automatic xfer(input logic rnw, input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] wd, output logic [31:0] rd, output int lat,
                      output logic upd);
    OPB_RNW = rnw; OPB_ABus = addr; OPB_BE = be; OPB_DBus = wd; OPB_select = 1'b1;
    rd = '0; lat = 0; upd = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge OPB_Clk);
      if (Sl_xferAck) begin
        lat = i;
        rd  = Sl_DBus;
        break;
      end
    end
    if (lat != 0) begin
      @(posedge OPB_Clk);
      #1;
    end
    OPB_select = 1'b0; OPB_RNW = 1'b1; OPB_DBus = '0; OPB_BE = '0;
    @(negedge OPB_Clk);
    upd = user_update;
    check("idle_ack", Sl_xferAck, 1'b0);
    check("idle_dbus", Sl_DBus, 32'h0);
  endtask

  logic [31:0]  rd;
  int           lat;
  logic         upd;
  logic [127:0] ud_save;
  logic [5:0]   pat;
  logic [31:0]  r0_exp;

  initial begin
    OPB_Rst = 1'b1; OPB_select = 1'b0; OPB_ABus = '0; OPB_BE = '0;
    OPB_DBus = '0; OPB_RNW = 1'b1; OPB_seqAddr = 1'b0;
    repeat (2) @(negedge OPB_Clk);
    OPB_Rst = 1'b0;

    check("rst_ack", Sl_xferAck, 1'b0);
    check("rst_dbus", Sl_DBus, 32'h0);
    check("rst_upd", user_update, 1'b0);
    check("rst_side", {Sl_errAck, Sl_retry, Sl_toutSup}, 3'b000);
    check("rst_ud", user_data_out, {4{INIT}});

    xfer(1'b1, BASE, 4'hF, 32'h0, rd, lat, upd);
    check("rd0_lat", lat, 1);
    check("rd0_data", rd, INIT);
    check("rd0_upd", upd, 1'b0);

`ifndef OPB_REG_BANK_COMMIT_EN
    xfer(1'b0, BASE + 4, 4'b1111, 32'h1234_5678, rd, lat, upd);
    check("wr1_lat", lat, 1);
    check("wr1_upd", upd, 1'b1);
    check("wr1_ud", user_data_out[63:32], 32'h1234_5678);

    xfer(1'b0, BASE + 4, 4'b0100, 32'h00FF_0000, rd, lat, upd);
    check("wr1be_upd", upd, 1'b1);
    check("wr1be_ud", user_data_out[63:32], 32'h12FF_5678);

    xfer(1'b1, BASE + 4, 4'hF, 32'h0, rd, lat, upd);
    check("rd1_data", rd, 32'h12FF_5678);
    check("rd1_upd", upd, 1'b0);

    xfer(1'b0, BASE + 32'h0F, 4'b0011, 32'hDEAD_BEEF, rd, lat, upd);
    check("wr3_ud", user_data_out[127:96], 32'hA5A5_BEEF);

    xfer(1'b0, BASE + 16, 4'hF, 32'hFFFF_FFFF, rd, lat, upd);
    check("wr4_lat", lat, 1);
    check("wr4_upd", upd, 1'b0);
    check("wr4_ud", user_data_out, {32'hA5A5_BEEF, INIT, 32'h12FF_5678, INIT});

    xfer(1'b1, BASE + 16, 4'hF, 32'h0, rd, lat, upd);
    check("rd4_lat", lat, 1);
    check("rd4_data", rd, 32'h0);
    r0_exp = INIT;
`else
    xfer(1'b0, BASE, 4'hF, 32'h1, rd, lat, upd);
    check("sh0_upd", upd, 1'b0);
    xfer(1'b0, BASE + 12, 4'hF, 32'h3, rd, lat, upd);
    check("sh3_upd", upd, 1'b0);
    check("sh_ud", user_data_out, {4{INIT}});

    xfer(1'b1, BASE + 16, 4'hF, 32'h0, rd, lat, upd);
    check("ctl_pend", rd, 32'h1);
    xfer(1'b1, BASE, 4'hF, 32'h0, rd, lat, upd);
    check("sh0_rd", rd, 32'h1);

    xfer(1'b0, BASE + 16, 4'hF, 32'h0, rd, lat, upd);
    check("ctl0_upd", upd, 1'b0);
    xfer(1'b1, BASE + 16, 4'hF, 32'h0, rd, lat, upd);
    check("ctl0_pend", rd, 32'h1);

    xfer(1'b0, BASE + 16, 4'hF, 32'h1, rd, lat, upd);
    check("cmt_upd", upd, 1'b1);
    check("cmt_ud", user_data_out, {32'h3, INIT, INIT, 32'h1});
    xfer(1'b1, BASE + 16, 4'hF, 32'h0, rd, lat, upd);
    check("cmt_pend", rd, 32'h0);
    r0_exp = 32'h1;
`endif

    pat = 6'b101010;
    OPB_RNW = 1'b1; OPB_ABus = BASE; OPB_BE = 4'hF; OPB_select = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge OPB_Clk);
      check($sformatf("hold_ack%0d", i), Sl_xferAck, pat[i]);
      check($sformatf("hold_dbus%0d", i), Sl_DBus, pat[i] ? r0_exp : 32'h0);
    end
    OPB_select = 1'b0;
    @(negedge OPB_Clk);

    ud_save = user_data_out;
    xfer(1'b1, HIGH + 4, 4'hF, 32'h0, rd, lat, upd);
    check("oow_rd_lat", lat, 0);
    xfer(1'b0, HIGH + 4, 4'hF, 32'hFFFF_FFFF, rd, lat, upd);
    check("oow_wr_lat", lat, 0);
    check("oow_wr_upd", upd, 1'b0);
    check("oow_wr_ud", user_data_out, ud_save);
    xfer(1'b0, BASE - 4, 4'hF, 32'hFFFF_FFFF, rd, lat, upd);
    check("below_lat", lat, 0);

    OPB_Rst = 1'b1; OPB_select = 1'b1; OPB_RNW = 1'b0; OPB_ABus = BASE + 8;
    OPB_BE = 4'hF; OPB_DBus = 32'hFFFF_FFFF;
    @(negedge OPB_Clk);
    check("abort_ack", Sl_xferAck, 1'b0);
    check("abort_upd", user_update, 1'b0);
    check("abort_ud", user_data_out, {4{INIT}});
    OPB_Rst = 1'b0; OPB_select = 1'b0;

    xfer(1'b1, BASE + 8, 4'hF, 32'h0, rd, lat, upd);
    check("post_rst_lat", lat, 1);
    check("post_rst_rd", rd, INIT);
    xfer(1'b0, BASE + 8, 4'hF, 32'h0000_0042, rd, lat, upd);
    check("post_wr_upd", upd, !COMMIT);
    xfer(1'b1, BASE + 8, 4'hF, 32'h0, rd, lat, upd);
    check("post_wr_rd", rd, 32'h0000_0042);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
